// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parametrised serial-pattern detector.
package seq_det_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      ARMED = 1'b1
   } state_e;

   localparam int         DEF_PAT_W = 4;
   localparam logic [3:0] DEF_PAT   = 4'b1101;
   localparam int         DEF_CNT_W = 8;

   // The fill counter must hold values up to PAT_W-1, with one bit of headroom.
   function automatic int fill_w(input int pat_w);
      return $clog2(pat_w) + 1;
   endfunction

endpackage

// File: rtl/seq_hist_reg.sv
// History shift register of accepted bits, with a saturating fill counter
// that tracks how many bits have arrived since the last clear.
module seq_hist_reg
   import seq_det_pkg::*;
#(
   parameter int PAT_W  = DEF_PAT_W,
   parameter int FILL_W = fill_w(PAT_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              shift,
   input  logic              clear,
   input  logic              fill_clr,
   input  logic              in_bit,
   output logic [PAT_W-1:0]  seq,
   output logic [FILL_W-1:0] fill
);

   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
   localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

   logic [PAT_W-1:0]  seq_d,  seq_q;
   logic [FILL_W-1:0] fill_d, fill_q;

   // Clear wins over shift; fill_clr restarts the count while the bit still shifts in.
   always_comb begin
      seq_d  = seq_q;
      fill_d = fill_q;
      if (clear) begin
         seq_d  = '0;
         fill_d = '0;
      end else if (shift) begin
         seq_d = {seq_q[PAT_W-2:0], in_bit};
         if (fill_clr) begin
            fill_d = '0;
         end else if (fill_q < FILL_MAX) begin
            fill_d = fill_q + FILL_ONE;
         end else begin
            fill_d = fill_q;
         end
      end else begin
         seq_d  = seq_q;
         fill_d = fill_q;
      end
   end

   // History and fill registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seq_q  <= '0;
         fill_q <= '0;
      end else begin
         seq_q  <= seq_d;
         fill_q <= fill_d;
      end
   end

   assign seq  = seq_q;
   assign fill = fill_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable Mealy serial-pattern detector with overlap modes,
// input qualifier and saturating match counter.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int               PAT_W       = DEF_PAT_W,
   parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(DEF_PAT),
   parameter int               CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pat,
   input  logic             cfg_overlap,
   output logic             out,
   output logic [PAT_W-1:0] seq,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int                FILL_W   = fill_w(PAT_W);
   localparam logic [FILL_W-1:0] ARM_FROM = FILL_W'(PAT_W - 2);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   logic [PAT_W-1:0]  pat_d, pat_q;
   logic              ovl_d, ovl_q;
   state_e            state_d, state_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;

   logic              accept_s;
   logic              match_s;
   logic [PAT_W-1:0]  window_s;
   logic [PAT_W-1:0]  seq_s;
   logic [FILL_W-1:0] fill_s;

   seq_hist_reg #(
      .PAT_W  (PAT_W),
      .FILL_W (FILL_W)
   ) u_hist (
      .clk      (clk),
      .rst      (rst),
      .shift    (accept_s),
      .clear    (cfg_load),
      .fill_clr (match_s & ~ovl_q),
      .in_bit   (in),
      .seq      (seq_s),
      .fill     (fill_s)
   );

   // A bit arriving with a config load is dropped, so it can never complete a match.
   always_comb begin
      accept_s = in_valid & ~cfg_load;
      window_s = {seq_s[PAT_W-2:0], in};
      match_s  = (state_q == ARMED) && accept_s && (window_s == pat_q);
   end

   // Pattern and mode registers are only written by the load strobe.
   always_comb begin
      pat_d = pat_q;
      ovl_d = ovl_q;
      if (cfg_load) begin
         pat_d = cfg_pat;
         ovl_d = cfg_overlap;
      end else begin
         pat_d = pat_q;
         ovl_d = ovl_q;
      end
   end

   // FSM next state: arm when the accepted bit completes the window.
   always_comb begin
      state_d = state_q;
      if (cfg_load) begin
         state_d = FILL;
      end else begin
         case (state_q)
            FILL: begin
               if (accept_s && (fill_s == ARM_FROM)) begin
                  state_d = ARMED;
               end else begin
                  state_d = FILL;
               end
            end
            ARMED: begin
               if (match_s && !ovl_q) begin
                  state_d = FILL;
               end else begin
                  state_d = ARMED;
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   // Saturating match counter.
   always_comb begin
      cnt_d = cnt_q;
      if (cfg_load) begin
         cnt_d = '0;
      end else if (match_s && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Control registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q   <= DEFAULT_PAT;
         ovl_q   <= 1'b1;
         state_q <= FILL;
         cnt_q   <= '0;
      end else begin
         pat_q   <= pat_d;
         ovl_q   <= ovl_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out       = match_s;
   assign seq       = seq_s;
   assign match_cnt = cnt_q;

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised, runtime-programmable Mealy serial-pattern detector; next generation of the fixed 4-bit sequence detector. Accepts one serial bit per qualified cycle and asserts `out` combinationally in the same cycle as the bit that completes the programmed pattern. Adds a configurable pattern width, a runtime-loadable pattern, overlapping and non-overlapping match modes, an input-valid qualifier and a saturating match counter. Sits between a serial bit source (testbench or deserialiser) and downstream control logic that consumes `out`.

## Interface
- `PAT_W`, 4: pattern/history width in bits; legal range 2..16.
- `DEFAULT_PAT`, 4'b1101: pattern after reset; `PAT_W` bits wide.
- `CNT_W`, 8: match counter width; minimum 2.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in` is sampled only in cycles where this is high.
- `in` in 1: serial data bit.
- `cfg_load` in 1: one-cycle strobe that loads `cfg_pat` and `cfg_overlap`.
- `cfg_pat` in `PAT_W`: new pattern; MSB is the oldest bit.
- `cfg_overlap` in 1: 1 selects overlapping matches, 0 selects non-overlapping.
- `out` out 1: Mealy match flag (combinational).
- `seq` out `PAT_W`: history of accepted bits; LSB is the newest bit.
- `match_cnt` out `CNT_W`: number of matches, saturating.

## Operation
- Reset (`rst`=0) values: `seq`=0, fill=0, state=FILL, pattern=`DEFAULT_PAT`, overlap=1, `match_cnt`=0, `out`=0.
- History: on an accepted bit (`in_valid`=1, `cfg_load`=0), `seq` <= {`seq`[PAT_W-2:0], `in`}. When `in_valid`=0, all state holds.
- Fill counter: width is $clog2(PAT_W)+1. It increments on each accepted bit and saturates at PAT_W-1.
- States:
  - FILL: fill < PAT_W-1. `out` is forced to 0.
  - ARMED: fill == PAT_W-1.
  - FILL -> ARMED when the accepted bit brings fill to PAT_W-1.
- Match condition: `out` = ARMED && `in_valid` && !`cfg_load` && ({`seq`[PAT_W-2:0], `in`} == pattern).
- On a match:
  - `match_cnt` increments; it holds at all-ones once saturated.
  - Overlap=1: the block remains ARMED.
  - Overlap=0: fill is cleared to 0 and the block returns to FILL. The next match therefore needs PAT_W fresh bits. `seq` still shifts normally.
- `cfg_load`=1:
  - Pattern and overlap are loaded.
  - `seq`, fill and `match_cnt` are cleared, and state returns to FILL.
  - A bit presented in the same cycle is discarded, and `out` is 0 in that cycle.
- Reset asserted mid-stream: all registers clear immediately, without waiting for a clock edge. `out` drops combinationally in the same instant.

## Timing
- `out` latency is 0 cycles: it is valid in the same cycle as the completing bit, before the rising edge.
- The bench must drive `in`, `in_valid` and `cfg_*` away from the rising edge of `clk`. It must sample `out` just before that edge.
- `seq`, `match_cnt` and state reflect an accepted bit one edge after it is presented.
- A new pattern is effective for the bit accepted on the cycle after the `cfg_load` edge. The first possible match comes PAT_W accepted bits after the load.
- Reset release: the first bit can be accepted on the first rising edge after `rst` goes high.

## Structure
- Shared package `seq_det_pkg`:
  - state enum {FILL, ARMED};
  - default `PAT_W`, `DEFAULT_PAT` and `CNT_W` constants;
  - a function returning the fill-counter width for a given `PAT_W`.
- Sub-module `seq_hist_reg` contains the history shift register plus the fill counter, with shift, clear and saturate controls.
- The top level holds:
  - the pattern and mode registers;
  - the FSM;
  - the comparator and Mealy output;
  - the saturating counter.

## Test plan
All scenarios use `PAT_W`=4, `DEFAULT_PAT`=1101 and `CNT_W`=8 unless stated otherwise.
- Reset hold: `rst`=0 with `in_valid`=1 and `in`=1 for 3 cycles -> `out`=0, `seq`=0, `match_cnt`=0 throughout.
- Overlap (default): accept stream 1101101101 -> `out` high on bits 4, 7 and 10; `match_cnt`=3; final `seq`=4'b1101.
- Non-overlap: load `cfg_pat`=1101 with `cfg_overlap`=0, then accept 1101101101 -> `out` high on bits 4 and 10 only; `match_cnt`=2.
- Bubbles and same-cycle load:
  - Accept 1,1,0,1 with two `in_valid`=0 cycles between each pair of bits -> single match on the 4th accepted bit.
  - Then assert `cfg_load` (`cfg_pat`=0110) together with `in_valid`=1 -> `out`=0 that cycle, `match_cnt`=0, `seq`=0.
  - Then accept 0110 -> match.
- Saturation: build with `CNT_W`=2, overlap=1, and accept 1111111 with pattern 1111 -> 4 matches occur (bits 4 to 7); `match_cnt` sticks at 3.
- Async reset mid-pattern: accept 110, then drive `rst` low between clock edges -> `seq` and fill clear immediately. After release, the 4th bit 1 alone gives no match; the full 1101 gives a match.
